// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer and its MAC.
// Optional saturating arithmetic is enabled by defining MATMUL_SAT_EN.
package matmul_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DIM_W  = 4;
  localparam int MAX_DIM    = 1 << DEF_DIM_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic int max_dim(input int dim_w);
    return 1 << dim_w;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate used once per operand pair; the product of a
// read issued in cycle t arrives in cycle t+1. MATMUL_SAT_EN adds clamping.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_clr,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
`ifdef MATMUL_SAT_EN
  input  logic              sat_clr,
  output logic              sat,
`endif
  output logic [DATA_W-1:0] acc
);

  logic              vld;
  logic [DATA_W-1:0] acc_next;

`ifdef MATMUL_SAT_EN
  localparam logic signed [2*DATA_W-1:0] PROD_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] PROD_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ACC_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ACC_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          prod_c;
  logic [DATA_W:0]            sum;
  logic                       clamp;

  // Clamp the full-width product first, then clamp the add; either sets the flag.
  always_comb begin
    prod   = $signed(a) * $signed(b);
    prod_c = prod[DATA_W-1:0];
    clamp  = 1'b0;
    if (prod > PROD_MAX) begin
      prod_c = ACC_MAX;
      clamp  = 1'b1;
    end else if (prod < PROD_MIN) begin
      prod_c = ACC_MIN;
      clamp  = 1'b1;
    end
    sum      = {acc[DATA_W-1], acc} + {prod_c[DATA_W-1], prod_c};
    acc_next = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      acc_next = sum[DATA_W] ? ACC_MIN : ACC_MAX;
      clamp    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (sat_clr) begin
      sat <= 1'b0;
    end else if (vld && clamp) begin
      sat <= 1'b1;
    end
  end
`else
  always_comb begin
    acc_next = acc + (a * b);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      acc <= '0;
    end else begin
      vld <= rd_en;
      if (acc_clr) begin
        acc <= '0;
      end else if (vld) begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Row-major sequencer for C = A*B over one shared MAC; writes each C element
// after K reads plus a drain cycle. MATMUL_SAT_EN exposes sticky sat_o.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DIM_W:0]    dim_m_i,
  input  logic [DIM_W:0]    dim_k_i,
  input  logic [DIM_W:0]    dim_n_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              a_rd_en_o,
  output logic [DIM_W-1:0]  a_row_o,
  output logic [DIM_W-1:0]  a_col_o,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              b_rd_en_o,
  output logic [DIM_W-1:0]  b_row_o,
  output logic [DIM_W-1:0]  b_col_o,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              c_wr_en_o,
  output logic [DIM_W-1:0]  c_row_o,
  output logic [DIM_W-1:0]  c_col_o,
`ifdef MATMUL_SAT_EN
  output logic              sat_o,
`endif
  output logic [DATA_W-1:0] c_data_o
);

  localparam logic [DIM_W:0] MAX_D = (DIM_W+1)'(max_dim(DIM_W));

  state_t         state;
  logic [DIM_W:0] dim_m_reg, dim_k_reg, dim_n_reg;
  logic [DIM_W-1:0] i_reg, j_reg, k_reg;
  logic           rd_en_reg, c_wr_reg, busy_reg, done_reg, err_reg;
  logic           dims_ok, accept, k_last, j_last, i_last, acc_clr;

  assign dims_ok = (dim_m_i != '0) && (dim_m_i <= MAX_D) &&
                   (dim_k_i != '0) && (dim_k_i <= MAX_D) &&
                   (dim_n_i != '0) && (dim_n_i <= MAX_D);
  assign accept  = (state == ST_IDLE) && start_i && dims_ok;
  assign k_last  = ({1'b0, k_reg} == dim_k_reg - 1'b1);
  assign j_last  = ({1'b0, j_reg} == dim_n_reg - 1'b1);
  assign i_last  = ({1'b0, i_reg} == dim_m_reg - 1'b1);
  assign acc_clr = accept || (state == ST_WRITE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      dim_m_reg <= '0;
      dim_k_reg <= '0;
      dim_n_reg <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      rd_en_reg <= 1'b0;
      c_wr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      c_wr_reg <= 1'b0;
      if (abort_i && state != ST_IDLE) begin
        state     <= ST_IDLE;
        busy_reg  <= 1'b0;
        rd_en_reg <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i && !dims_ok) begin
              err_reg  <= 1'b1;
              done_reg <= 1'b1;
            end else if (accept) begin
              dim_m_reg <= dim_m_i;
              dim_k_reg <= dim_k_i;
              dim_n_reg <= dim_n_i;
              i_reg     <= '0;
              j_reg     <= '0;
              k_reg     <= '0;
              busy_reg  <= 1'b1;
              rd_en_reg <= 1'b1;
              state     <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (k_last) begin
              rd_en_reg <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
          ST_DRAIN: begin
            c_wr_reg <= 1'b1;
            state    <= ST_WRITE;
          end
          ST_WRITE: begin
            k_reg <= '0;
            if (i_last && j_last) begin
              done_reg <= 1'b1;
              busy_reg <= 1'b0;
              state    <= ST_DONE;
            end else begin
              if (j_last) begin
                j_reg <= '0;
                i_reg <= i_reg + 1'b1;
              end else begin
                j_reg <= j_reg + 1'b1;
              end
              rd_en_reg <= 1'b1;
              state     <= ST_RUN;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // The write strobe is already registered when abort arrives in WRITE, so gate it here.
  assign c_wr_en_o = c_wr_reg & ~abort_i;
  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign err_o     = err_reg;
  assign a_rd_en_o = rd_en_reg;
  assign b_rd_en_o = rd_en_reg;
  assign a_row_o   = i_reg;
  assign a_col_o   = k_reg;
  assign b_row_o   = k_reg;
  assign b_col_o   = j_reg;
  assign c_row_o   = i_reg;
  assign c_col_o   = j_reg;

  matmul_mac #(.DATA_W(DATA_W)) u_mac (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .acc_clr (acc_clr),
    .rd_en   (rd_en_reg),
    .a       (a_data_i),
    .b       (b_data_i),
`ifdef MATMUL_SAT_EN
    .sat_clr (accept),
    .sat     (sat_o),
`endif
    .acc     (c_data_o)
  );

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that sequences one shared 32-bit multiply-accumulate datapath over the A/B operand stores and writes each C element back.
- Sits between the Wishbone-facing accelerator register block and the matrix memories. Start, dimensions and abort come from the operation registers; done/busy/err go back to them.
- Replaces fully parallel matrix multiplication with a time-multiplexed, row-major schedule.

Parameters:
- DATA_W, 32, operand/accumulator width
- DIM_W, 4, index width; max dimension is 2**DIM_W (16)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle start request, sampled only in IDLE
- abort_i  in  1  cancel the running operation
- dim_m_i  in  DIM_W+1  rows of A and C
- dim_k_i  in  DIM_W+1  columns of A, rows of B
- dim_n_i  in  DIM_W+1  columns of B and C
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse when dimensions are rejected
- a_rd_en_o  out  1  A read strobe
- a_row_o / a_col_o  out  DIM_W each  A index (i,k)
- a_data_i  in  DATA_W  A data, valid 1 cycle after a_rd_en_o
- b_rd_en_o  out  1  B read strobe
- b_row_o / b_col_o  out  DIM_W each  B index (k,j)
- b_data_i  in  DATA_W  B data, valid 1 cycle after b_rd_en_o
- c_wr_en_o  out  1  C write strobe
- c_row_o / c_col_o  out  DIM_W each  C index (i,j)
- c_data_o  out  DATA_W  C write data

Behaviour:
- Reset values:
  - All outputs 0; indices 0.
  - Accumulator 0; state IDLE.
  - Reset mid-operation aborts immediately with no further writes.
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start_i=1 with any dim equal to 0 or greater than 2**DIM_W: err_o and done_o pulse high the next cycle, busy_o stays 0, no memory traffic.
  - start_i=1 with valid dims: latch the dims, set i=j=k=0, accumulator=0, busy_o=1, go to RUN.
- RUN:
  - Each cycle, a_rd_en_o=b_rd_en_o=1 with A(i,k) and B(k,j); then k++.
  - After issuing k=K-1, go to DRAIN.
- Accumulation:
  - A registered valid follows the read strobe by 1 cycle.
  - When valid, acc <= acc + a*b, using the low DATA_W bits of the signed product, wrapping mod 2**DATA_W.
- DRAIN: one cycle; the final product accumulates.
- WRITE:
  - c_wr_en_o=1 for one cycle, with c_data_o=acc and (c_row_o,c_col_o)=(i,j).
  - Clear acc and k.
  - Advance j; when j wraps at N, clear j and increment i.
  - If this was the element (M-1,N-1), go to DONE; otherwise go to RUN.
- DONE: done_o=1 for one cycle, busy_o falls in the same cycle, return to IDLE.
- Timing:
  - Start sampled at cycle 0. Element e (0-based) is written in cycle (e+1)*(K+2).
  - done_o asserts in cycle M*N*(K+2)+1.
  - Strobes are never asserted in DRAIN, WRITE or DONE.
- abort_i in any non-IDLE state:
  - Next cycle: state IDLE, busy_o=0, all strobes 0, no done_o.
  - abort_i has priority over start_i, and over a WRITE in the same cycle (that write is suppressed).
- start_i while busy_o=1 is ignored.
- Dimension inputs are ignored after latch.

Optional Feature:
- Macro: MATMUL_SAT_EN.
- Defined:
  - Accumulation saturates to signed DATA_W limits: 0x7FFF_FFFF / 0x8000_0000, applied per add step.
  - The 64-bit product is first clamped to the DATA_W range.
  - Sticky flag output sat_o (1 bit) is set on any clamp and cleared at the next accepted start.
- Undefined: wrap-around arithmetic and no sat_o port.

Decomposition:
- Package matmul_pkg: state enum type, DATA_W/DIM_W defaults, and the max-dimension constant.
- One natural sub-module, matmul_mac:
  - Registered accumulator with clear, valid and sat logic.
  - The sequencer holds the FSM and index counters only.

Test Plan:
- M=K=N=2, A=identity, B={1,2,3,4} -> writes C(0,0)=1, C(0,1)=2, C(1,0)=3, C(1,1)=4 in cycles 4, 8, 12, 16; done_o at cycle 17; busy_o high cycles 1-16.
- M=1, K=3, N=1, A={1,2,3}, B={4,5,6} -> single write of 32 at cycle 5; done_o at cycle 6.
- dim_k=0 or dim_n=17 with start -> err_o and done_o pulse next cycle; no strobes; busy_o stays 0.
- M=K=N=4 with abort_i at cycle 10 -> strobes 0 from cycle 11; exactly 1 write (cycle 6) seen; no done_o; a new start then completes normally.
- A=B=0x7FFF_FFFF, K=2 -> without MATMUL_SAT_EN, C equals the wrapped sum 0x0000_0002; with it, C=0x7FFF_FFFF and sat_o=1.
- wb_rst_ni asserted mid-RUN -> all outputs 0 immediately (async); no write after release until a new start.
